// File: rtl/banked_register_file.sv
// Banked register file of byte-pair registers.
// General pairs are replicated per bank; SP and PC are shared by all banks.
// Supports byte writes, pair writes, increment/decrement, pair exchange and
// bank advance, all committed at the rising clock edge. Reads are combinational.
module banked_register_file #(
  parameter int XLEN   = 8,
  parameter int NPAIRS = 4,
  parameter int NBANKS = 2,
  parameter logic [2*XLEN-1:0] SP_RESET = '0,
  localparam int PW = $clog2(NPAIRS + 2),
  localparam int BW = (NBANKS > 1) ? $clog2(NBANKS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [PW-1:0]     wr_pair,
  input  logic              wr_hi,
  input  logic [XLEN-1:0]   wr_data,
  input  logic              pwr_en,
  input  logic [PW-1:0]     pwr_pair,
  input  logic [2*XLEN-1:0] pwr_data,
  input  logic [1:0]        idu_op,
  input  logic [PW-1:0]     idu_pair,
  input  logic              xchg_en,
  input  logic [PW-1:0]     xchg_a,
  input  logic [PW-1:0]     xchg_b,
  input  logic              bank_next,
  input  logic [PW-1:0]     rd_pair_a,
  input  logic [PW-1:0]     rd_pair_b,
  output logic [2*XLEN-1:0] rpdata_a,
  output logic [2*XLEN-1:0] rpdata_b,
  input  logic              rd_hi,
  output logic [XLEN-1:0]   rdata,
  output logic [2*XLEN-1:0] idu_result,
  output logic [BW-1:0]     bank
);

  localparam int PRW    = 2 * XLEN;
  localparam int NREGS  = NPAIRS + 2;
  localparam int SP_IDX = NPAIRS;
  localparam int PC_IDX = NPAIRS + 1;

  localparam logic [1:0] IDU_INC = 2'b01;
  localparam logic [1:0] IDU_DEC = 2'b10;

  // Architectural state: general pairs held as separate hi/lo bytes per bank.
  logic [XLEN-1:0] gp_hi_q [NBANKS][NPAIRS];
  logic [XLEN-1:0] gp_lo_q [NBANKS][NPAIRS];
  logic [PRW-1:0]  sp_q;
  logic [PRW-1:0]  pc_q;
  logic [BW-1:0]   bank_q;
  logic [BW-1:0]   bank_d;

  // Flat view of the registers visible through the active bank, and its next state.
  logic [PRW-1:0]  pair_cur [NREGS];
  logic [PRW-1:0]  pair_d   [NREGS];
  logic [PRW-1:0]  idu_src;

  // Indices past PC address nothing: reads return 0, writes are dropped.
  function automatic logic idx_ok(input logic [PW-1:0] idx);
    return int'(idx) < NREGS;
  endfunction

  // Assemble the pre-edge view of the active bank plus SP and PC.
  always_comb begin
    for (int p = 0; p < NPAIRS; p++) begin
      pair_cur[p] = {gp_hi_q[bank_q][p], gp_lo_q[bank_q][p]};
    end
    pair_cur[SP_IDX] = sp_q;
    pair_cur[PC_IDX] = pc_q;
  end

  assign rpdata_a = idx_ok(rd_pair_a) ? pair_cur[rd_pair_a] : '0;
  assign rpdata_b = idx_ok(rd_pair_b) ? pair_cur[rd_pair_b] : '0;
  assign rdata    = rd_hi ? rpdata_a[PRW-1:XLEN] : rpdata_a[XLEN-1:0];
  assign bank     = bank_q;

  // Increment/decrement unit, always computed from pre-edge state.
  always_comb begin
    idu_src = idx_ok(idu_pair) ? pair_cur[idu_pair] : '0;
    case (idu_op)
      IDU_INC: idu_result = idu_src + PRW'(1);
      IDU_DEC: idu_result = idu_src - PRW'(1);
      default: idu_result = idu_src;
    endcase
  end

  // Next-state merge: xchg, then idu, then pwr, then byte write; later wins per byte.
  always_comb begin
    // NOTE: every element gets a default first so partial assignments below never infer latches.
    for (int p = 0; p < NREGS; p++) begin
      pair_d[p] = pair_cur[p];
    end
    if (xchg_en && idx_ok(xchg_a) && idx_ok(xchg_b)) begin
      pair_d[xchg_a] = pair_cur[xchg_b];
      pair_d[xchg_b] = pair_cur[xchg_a];
    end
    if ((idu_op == IDU_INC || idu_op == IDU_DEC) && idx_ok(idu_pair)) begin
      pair_d[idu_pair] = idu_result;
    end
    if (pwr_en && idx_ok(pwr_pair)) begin
      pair_d[pwr_pair] = pwr_data;
    end
    if (wr_en && idx_ok(wr_pair)) begin
      if (wr_hi) begin
        pair_d[wr_pair][PRW-1:XLEN] = wr_data;
      end else begin
        pair_d[wr_pair][XLEN-1:0] = wr_data;
      end
    end
  end

  // Bank advance wraps at NBANKS; a single-bank file never moves.
  always_comb begin
    bank_d = bank_q;
    if (bank_next && NBANKS > 1) begin
      bank_d = (int'(bank_q) == NBANKS - 1) ? '0 : bank_q + BW'(1);
    end
  end

  // State commit; only the bank that was active before the edge is written.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the pair storage is reset on purpose; software relies on every bank reading zero after reset.
      for (int b = 0; b < NBANKS; b++) begin
        for (int p = 0; p < NPAIRS; p++) begin
          gp_hi_q[b][p] <= '0;
          gp_lo_q[b][p] <= '0;
        end
      end
      sp_q   <= SP_RESET;
      pc_q   <= '0;
      bank_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      for (int p = 0; p < NPAIRS; p++) begin
        gp_hi_q[bank_q][p] <= pair_d[p][PRW-1:XLEN];
        gp_lo_q[bank_q][p] <= pair_d[p][XLEN-1:0];
      end
      sp_q   <= pair_d[SP_IDX];
      pc_q   <= pair_d[PC_IDX];
      bank_q <= bank_d;
    end
  end

endmodule

// File: doc/banked_register_file.md
BANKED_REGISTER_FILE -- requirements
Module: banked_register_file

Interface
REQ-001 SHALL have parameter XLEN, default 8, giving the byte width; pair width is 2*XLEN.
REQ-002 SHALL have parameter NPAIRS, default 4, giving the number of general pairs per bank, each stored as hi byte and lo byte.
REQ-003 SHALL have parameter NBANKS, default 2, giving the number of general-pair banks; NBANKS >= 1.
REQ-004 SHALL have parameter SP_RESET, default 0, giving the SP reset value.
REQ-005 SHALL use pair index width PW = clog2(NPAIRS+2); index 0..NPAIRS-1 = general pair (active bank), NPAIRS = SP, NPAIRS+1 = PC.
REQ-006 Ports, in order:
  clk  in  1  clock, rising edge
  rst  in  1  reset, synchronous, active-high
  wr_en  in  1  byte write strobe
  wr_pair  in  PW  byte write pair index
  wr_hi  in  1  1 = hi byte, 0 = lo byte
  wr_data  in  XLEN  byte write data
  pwr_en  in  1  pair write strobe
  pwr_pair  in  PW  pair write index
  pwr_data  in  2*XLEN  pair write data
  idu_op  in  2  00 none, 01 increment, 10 decrement, 11 none
  idu_pair  in  PW  inc/dec target
  xchg_en  in  1  exchange two pairs
  xchg_a, xchg_b  in  PW each  exchange operands
  bank_next  in  1  advance active bank
  rd_pair_a, rd_pair_b  in  PW each  read indices
  rpdata_a, rpdata_b  out  2*XLEN each  pair read data
  rd_hi  in  1  byte select applied to port A
  rdata  out  XLEN  byte of rpdata_a
  idu_result  out  2*XLEN  current inc/dec result
  bank  out  clog2(NBANKS), min 1  active bank index

Function
REQ-007 Reads SHALL be combinational from current state, with zero latency; rdata SHALL be rpdata_a[2*XLEN-1:XLEN] when rd_hi=1, else rpdata_a[XLEN-1:0].
REQ-008 A read of an index >= NPAIRS+2 SHALL return 0.
REQ-009 All writes SHALL take effect at the next rising clk edge; same-cycle reads SHALL return pre-edge values, with no write-through.
REQ-010 General-pair reads and writes SHALL address bank `bank`; SP and PC SHALL be unbanked.
REQ-011 idu_result SHALL be (pair[idu_pair] + 1) mod 2^(2*XLEN) for increment and (pair[idu_pair] - 1) mod 2^(2*XLEN) for decrement, i.e. FFFF+1 = 0000 and 0000-1 = FFFF at XLEN=8; it SHALL be the unmodified pair value when idu_op is none; the result SHALL be written back to idu_pair.
REQ-012 xchg_en SHALL swap the full contents of xchg_a and xchg_b in one cycle; xchg_a == xchg_b SHALL be a no-op.
REQ-013 Same-cycle operations SHALL be applied per byte in order xchg, idu, pwr, wr, with later operations overriding earlier ones on the same byte; operations on disjoint targets SHALL all take effect.
REQ-014 Operand values for xchg, idu and pwr SHALL always be pre-edge state, never the results of other same-cycle operations.
REQ-015 bank_next SHALL set bank to (bank+1) mod NBANKS at the edge; all other same-cycle operations SHALL use the old bank.
REQ-016 With NBANKS=1, bank_next SHALL have no effect and bank SHALL read 0.
REQ-017 Any write, inc/dec or exchange targeting an index >= NPAIRS+2 SHALL be ignored; other operations in the same cycle SHALL be unaffected.
REQ-018 Inactive banks SHALL retain their contents indefinitely.

Reset
REQ-019 With rst=1 at an edge, the block SHALL set PC=0, SP=SP_RESET, bank=0 and all general pairs in all banks to 0.
REQ-020 rst SHALL override every same-cycle operation, including a reset asserted mid-sequence.
REQ-021 rst SHALL drive outputs to their reset-derived values from the following cycle: rpdata=0 for general pairs and PC, SP_RESET for SP.

Verification
REQ-022 Reset then idle: after reset, a read of PC gives 0000, SP gives SP_RESET, pair 2 gives 0000, and bank = 0.
REQ-023 Wrap-around: pwr pair 1 = FFFF, then increment pair 1 -> 0000; then decrement -> FFFF; idu_result is valid in the same cycle.
REQ-024 Bank swap: write pair 0 = 1234, then bank_next -> pair 0 reads 0000; write 5678 with bank_next in the same cycle -> 5678 is stored in bank 1, and bank 0 later reads 1234.
REQ-025 Collision: xchg pairs 0 and 1 (AAAA and BBBB) with wr_en hi of pair 0 = 11 in the same cycle -> pair 0 = 11BB, pair 1 = AAAA.
REQ-026 Illegal index: pwr to index NPAIRS+2 with an increment of PC in the same cycle -> PC increments and all other state is unchanged; a read of that index gives 0.
REQ-027 Reset mid-operation: rst held with pwr, idu, xchg and bank_next all active -> reset values only.
